alu_ctrl: RTL and testbench
===========================

# alu_ctrl

Operand-capture and arithmetic stage feeding the calculator's display stage: it debounces the enter button, latches operands A and B from the 8 board switches, and steps through ADD, SUB and MOD. It produces the registered a/b/result/sign/overflow/operand/valid bundle that the display stage renders. MOD is computed by iterative subtraction, so result latency depends on the data.

## Interface
- `DEBOUNCE_CYCLES`, default 1_000_000: stable-high cycles required before a press is accepted (10 ms at 100 MHz).
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-low reset.
- `sw` in 8: operand switches, asynchronous.
- `btn_enter` in 1: enter button, asynchronous, bouncy.
- `a` out 8: operand A.
- `b` out 8: operand B.
- `result` out 8: magnitude of the result.
- `sign` out 1: 1 = negative result (SUB only).
- `overflow` out 1: ADD carry-out, or MOD divide-by-zero.
- `operand` out 8: display symbol code of the current operation.
- `valid` out 1: result/sign/overflow are final for the current a, b, operand.

## Operation
- `btn_enter` passes through a 2-FF synchronizer and a debouncer, yielding a one-cycle `press` pulse.
  - A press is accepted once the input has been high for `DEBOUNCE_CYCLES` consecutive cycles.
  - Only one press is accepted per high period; the input must go low before the next press can be accepted.
- `sw` passes through a 2-FF synchronizer before use.
- States: `WAIT_A`, `WAIT_B`, `CALC`, `SHOW`.
- `WAIT_A`: `a` <= synchronized `sw` every cycle; `b`, `result`, `sign`, `overflow` held at 0; `valid`=0. On `press`: freeze `a`, go to `WAIT_B`.
- `WAIT_B`: `b` <= synchronized `sw` every cycle. On `press`: freeze `b`, op <= ADD, `rem` <= `a`, go to `CALC`.
- `CALC`: `valid`=0; `press` is ignored (dropped). Exit cycle: result, sign and overflow registered, `valid`<=1, go to `SHOW`.
  - ADD: {`overflow`,`result`} = `a`+`b` (9-bit); `sign`=0. Exit after one cycle.
  - SUB: if `a`>=`b`, `result`=`a`-`b`, `sign`=0; else `result`=`b`-`a`, `sign`=1. `overflow`=0. Exit after one cycle.
  - MOD with `b`=0: `result`=0, `overflow`=1, `sign`=0. Exit after one cycle.
  - MOD with `b`≠0: each cycle, if `rem`>=`b` then `rem`<=`rem`-`b`; else `result`<=`rem` and exit. `sign`=0, `overflow`=0.
- `SHOW`: outputs held, `valid`=1.
  - On `press` with op ADD: op <= SUB, `valid`<=0, `rem`<=`a`, go to `CALC`.
  - On `press` with op SUB: op <= MOD, same actions.
  - On `press` with op MOD: go to `WAIT_A`; `b`, `result`, `sign`, `overflow` cleared; op <= ADD.
- `operand` always equals the symbol code of op: ADD = `SYM_PLUS` (131), SUB = `SYM_MINUS` (130), MOD = `SYM_MOD` (132).

## Timing
- Reset values (async, on `rst`=0):
  - state = `WAIT_A`.
  - `a`, `b`, `result`, `rem` = 0.
  - `sign`, `overflow`, `valid` = 0.
  - `operand` = 131.
  - Debounce counter and synchronizers = 0.
- Reset mid-`CALC` aborts immediately to the reset values; no partial result is visible.
- `press` asserts at the (`DEBOUNCE_CYCLES`+2)th cycle after the raw rising edge, counting the 2 synchronizer cycles.
- Latency: `press` at cycle k (state `WAIT_B` or `SHOW`) puts state in `CALC` at k+1. `valid` rises at k+2+q, where q = floor(`a`/`b`) for MOD with `b`≠0, and q = 0 otherwise.
  - Worst case: 255/1 gives `valid` at k+257.
- `a` and `b` outputs lag `sw` by 3 cycles in the WAIT states (2 sync + 1 register).
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- `alu_pkg`: state enum, op enum (ADD/SUB/MOD), and `localparam` symbol codes `SYM_PLUS`=8'd131, `SYM_MINUS`=8'd130, `SYM_MOD`=8'd132. The display stage imports the same codes.
- Sub-module `button_debounce`:
  - Contents: synchronizer, saturating counter, one-shot pulse.
  - Parameter: `DEBOUNCE_CYCLES`.
  - Ports: `clk`, `rst`, `btn_in`, `press`.
- The `alu_ctrl` body holds the FSM, the datapath and the `sw` synchronizer.

## Test plan
- `DEBOUNCE_CYCLES`=4; high pulses of 3 cycles separated by lows -> no `press`. Then a steady 10-cycle high -> exactly one `press`, 6 cycles after the rise.
- A=200, B=100. ADD -> `result`=44, `overflow`=1, `operand`=131. Press -> SUB: `result`=100, `sign`=0, `operand`=130. Press -> MOD: `result`=0, `valid` at k+4.
- A=100, B=250, SUB -> `result`=150, `sign`=1, `overflow`=0, `valid` 2 cycles after the press.
- A=200, B=7, MOD -> `result`=4; `valid` low through k+29, high at k+30. Presses during `CALC` are ignored.
- A=9, B=0, MOD -> `result`=0, `overflow`=1, `valid` at k+2. Next press -> `WAIT_A` with `b`/`result`/`overflow` cleared and `operand`=131.
- Assert `rst` low during a MOD `CALC` with A=255, B=1 -> all outputs take reset values immediately. After release, `a` tracks `sw` again.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and display symbol codes for the calculator ALU stage.
package alu_pkg;

  typedef enum logic [1:0] {WAIT_A, WAIT_B, CALC, SHOW} state_t;
  typedef enum logic [1:0] {ADD, SUB, MOD} op_t;

  localparam logic [7:0] SYM_PLUS  = 8'd131;
  localparam logic [7:0] SYM_MINUS = 8'd130;
  localparam logic [7:0] SYM_MOD   = 8'd132;

  function automatic logic [7:0] op_symbol(input op_t op);
    case (op)
      SUB:     op_symbol = SYM_MINUS;
      MOD:     op_symbol = SYM_MOD;
      default: op_symbol = SYM_PLUS;
    endcase
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Synchronizes a bouncy button and emits one press pulse per stable high period.
module button_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic press
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          r_meta;
  logic          r_sync;
  logic [CW-1:0] r_cnt;
  logic          r_press;

  // Counter saturates at DEBOUNCE_CYCLES so the pulse fires once until the input drops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_meta  <= 1'b0;
      r_sync  <= 1'b0;
      r_cnt   <= '0;
      r_press <= 1'b0;
    end else begin
      r_meta  <= btn_in;
      r_sync  <= r_meta;
      r_press <= 1'b0;
      if (!r_sync) begin
        r_cnt <= '0;
      end else if (r_cnt != CW'(DEBOUNCE_CYCLES)) begin
        r_cnt   <= r_cnt + 1'b1;
        r_press <= (r_cnt == CW'(DEBOUNCE_CYCLES - 1));
      end
    end
  end

  assign press = r_press;

endmodule

// File: rtl/alu_ctrl.sv
// Operand capture and ADD/SUB/MOD sequencing; MOD uses iterative subtraction.
module alu_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] sw,
  input  logic       btn_enter,
  output logic [7:0] a,
  output logic [7:0] b,
  output logic [7:0] result,
  output logic       sign,
  output logic       overflow,
  output logic [7:0] operand,
  output logic       valid
);

  logic w_press;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
    .clk    (clk),
    .rst    (rst),
    .btn_in (btn_enter),
    .press  (w_press)
  );

  state_t     r_state, w_state;
  op_t        r_op, w_op;
  logic [7:0] r_a, w_a, r_b, w_b, r_result, w_result, r_rem, w_rem, r_operand, w_operand;
  logic       r_sign, w_sign, r_ovf, w_ovf, r_valid, w_valid;
  logic [7:0] r_sw_meta, r_sw_sync;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sw_meta <= '0;
      r_sw_sync <= '0;
      r_state   <= WAIT_A;
      r_op      <= ADD;
      r_a       <= '0;
      r_b       <= '0;
      r_result  <= '0;
      r_rem     <= '0;
      r_sign    <= 1'b0;
      r_ovf     <= 1'b0;
      r_valid   <= 1'b0;
      r_operand <= SYM_PLUS;
    end else begin
      r_sw_meta <= sw;
      r_sw_sync <= r_sw_meta;
      r_state   <= w_state;
      r_op      <= w_op;
      r_a       <= w_a;
      r_b       <= w_b;
      r_result  <= w_result;
      r_rem     <= w_rem;
      r_sign    <= w_sign;
      r_ovf     <= w_ovf;
      r_valid   <= w_valid;
      r_operand <= w_operand;
    end
  end

  always_comb begin
    w_state  = r_state;
    w_op     = r_op;
    w_a      = r_a;
    w_b      = r_b;
    w_result = r_result;
    w_rem    = r_rem;
    w_sign   = r_sign;
    w_ovf    = r_ovf;
    w_valid  = r_valid;
    case (r_state)
      WAIT_A: begin
        w_b      = '0;
        w_result = '0;
        w_sign   = 1'b0;
        w_ovf    = 1'b0;
        w_valid  = 1'b0;
        if (w_press) w_state = WAIT_B;
        else         w_a     = r_sw_sync;
      end
      WAIT_B: begin
        if (w_press) begin
          w_op    = ADD;
          w_rem   = r_a;
          w_state = CALC;
        end else begin
          w_b = r_sw_sync;
        end
      end
      CALC: begin
        w_valid = 1'b0;
        case (r_op)
          ADD: begin
            {w_ovf, w_result} = {1'b0, r_a} + {1'b0, r_b};
            w_sign  = 1'b0;
            w_valid = 1'b1;
            w_state = SHOW;
          end
          SUB: begin
            w_sign   = (r_a < r_b);
            w_result = (r_a < r_b) ? (r_b - r_a) : (r_a - r_b);
            w_ovf    = 1'b0;
            w_valid  = 1'b1;
            w_state  = SHOW;
          end
          MOD: begin
            w_sign = 1'b0;
            if (r_b == '0) begin
              w_result = '0;
              w_ovf    = 1'b1;
              w_valid  = 1'b1;
              w_state  = SHOW;
            end else if (r_rem >= r_b) begin
              w_rem = r_rem - r_b;
            end else begin
              w_result = r_rem;
              w_ovf    = 1'b0;
              w_valid  = 1'b1;
              w_state  = SHOW;
            end
          end
          default: begin
            w_op    = ADD;
            w_state = WAIT_A;
          end
        endcase
      end
      SHOW: begin
        if (w_press) begin
          w_valid = 1'b0;
          w_rem   = r_a;
          w_state = CALC;
          case (r_op)
            ADD: w_op = SUB;
            SUB: w_op = MOD;
            default: begin
              w_op     = ADD;
              w_state  = WAIT_A;
              w_b      = '0;
              w_result = '0;
              w_sign   = 1'b0;
              w_ovf    = 1'b0;
            end
          endcase
        end
      end
      default: w_state = WAIT_A;
    endcase
    w_operand = op_symbol(w_op);
  end

  assign a        = r_a;
  assign b        = r_b;
  assign result   = r_result;
  assign sign     = r_sign;
  assign overflow = r_ovf;
  assign operand  = r_operand;
  assign valid    = r_valid;

endmodule

// File: tb/tb_alu_ctrl.sv
// Self-checking bench for alu_ctrl: debounce timing, ADD/SUB/MOD sequences, reset abort.
module tb_alu_ctrl;

  localparam int unsigned DB = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       btn = 1'b0;
  logic [7:0] sw  = '0;
  logic [7:0] a, b, result, operand;
  logic       sign, overflow, valid;

  alu_ctrl #(.DEBOUNCE_CYCLES(DB)) dut (
    .clk       (clk),
    .rst       (rst),
    .sw        (sw),
    .btn_enter (btn),
    .a         (a),
    .b         (b),
    .result    (result),
    .sign      (sign),
    .overflow  (overflow),
    .operand   (operand),
    .valid     (valid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int a, b;
    int add_res, add_ovf;
    int sub_res, sub_sign;
    int mod_res, mod_ovf, mod_lat;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Latency counted in clock edges from the raw button rise: 2 sync + DB debounce
  // cycles to the press pulse, one edge into CALC, then 1 + quotient edges.
  function automatic vec_t model(input int va, input int vb);
    vec_t v;
    v.a        = va;
    v.b        = vb;
    v.add_res  = (va + vb) % 256;
    v.add_ovf  = (va + vb > 255) ? 1 : 0;
    v.sub_res  = (va >= vb) ? va - vb : vb - va;
    v.sub_sign = (va < vb) ? 1 : 0;
    if (vb == 0) begin
      v.mod_res = 0;
      v.mod_ovf = 1;
      v.mod_lat = DB + 4;
    end else begin
      v.mod_res = va % vb;
      v.mod_ovf = 0;
      v.mod_lat = DB + 4 + va / vb;
    end
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press_only();
    btn = 1'b1;
    repeat (8) tick();
    btn = 1'b0;
    repeat (4) tick();
  endtask

  // Raises the button and returns the edge index at which valid is first seen high.
  task automatic press_measure(input bit extra, output int lat);
    lat = -1;
    btn = 1'b1;
    for (int n = 1; n <= 400; n++) begin
      tick();
      btn = (n < 8) || (extra && n >= 12 && n < 20);
      if (n >= 7 && valid && lat < 0) lat = n;
      if (lat >= 0 && n >= 20) break;
    end
    btn = 1'b0;
    repeat (4) tick();
  endtask

  task automatic run_seq(input vec_t v, input bit extra);
    int lat;
    sw = v.a[7:0];
    repeat (4) tick();
    chk("a_track", a, v.a);
    press_only();
    sw = v.b[7:0];
    repeat (4) tick();
    chk("b_track", b, v.b);
    chk("a_frozen", a, v.a);
    chk("waitb_valid", valid, 0);

    press_measure(1'b0, lat);
    chk("add_lat", lat, DB + 4);
    chk("add_res", result, v.add_res);
    chk("add_ovf", overflow, v.add_ovf);
    chk("add_sign", sign, 0);
    chk("add_sym", operand, 131);

    press_measure(1'b0, lat);
    chk("sub_lat", lat, DB + 4);
    chk("sub_res", result, v.sub_res);
    chk("sub_sign", sign, v.sub_sign);
    chk("sub_ovf", overflow, 0);
    chk("sub_sym", operand, 130);

    press_measure(extra, lat);
    chk("mod_lat", lat, v.mod_lat);
    chk("mod_res", result, v.mod_res);
    chk("mod_ovf", overflow, v.mod_ovf);
    chk("mod_sign", sign, 0);
    chk("mod_sym", operand, 132);
    chk("mod_valid", valid, 1);

    press_only();
    chk("clr_b", b, 0);
    chk("clr_res", result, 0);
    chk("clr_ovf", overflow, 0);
    chk("clr_sign", sign, 0);
    chk("clr_valid", valid, 0);
    chk("clr_sym", operand, 131);
  endtask

  initial begin
    int pcnt, pat, lat;

    tbl.push_back('{200, 100,  44, 1, 100, 0,   0, 0, DB + 6});
    tbl.push_back('{100, 250,  94, 1, 150, 1, 100, 0, DB + 4});
    tbl.push_back('{200,   7, 207, 0, 193, 0,   4, 0, DB + 32});
    tbl.push_back('{  9,   0,   9, 0,   9, 0,   0, 1, DB + 4});
    for (int i = 0; i < 6; i++)
      tbl.push_back(model(int'($urandom_range(0, 255)),
                          (i == 0) ? 0 : int'($urandom_range(0, 255))));

    #12;
    chk("rst_a", a, 0);
    chk("rst_b", b, 0);
    chk("rst_res", result, 0);
    chk("rst_sign", sign, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_valid", valid, 0);
    chk("rst_sym", operand, 131);
    rst = 1'b1;
    tick();

    pcnt = 0;
    for (int r = 0; r < 3; r++) begin
      btn = 1'b1;
      for (int n = 0; n < 3; n++) begin
        tick();
        if (dut.u_debounce.press) pcnt++;
      end
      btn = 1'b0;
      for (int n = 0; n < 3; n++) begin
        tick();
        if (dut.u_debounce.press) pcnt++;
      end
    end
    repeat (4) begin
      tick();
      if (dut.u_debounce.press) pcnt++;
    end
    chk("short_pulse_press", pcnt, 0);

    pcnt = 0;
    pat  = -1;
    btn  = 1'b1;
    for (int n = 1; n <= 16; n++) begin
      tick();
      if (n == 10) btn = 1'b0;
      if (dut.u_debounce.press) begin
        pcnt++;
        if (pat < 0) pat = n;
      end
    end
    chk("steady_press_cnt", pcnt, 1);
    chk("steady_press_at", pat, DB + 2);

    #2 rst = 1'b0;
    #5 rst = 1'b1;
    tick();

    foreach (tbl[i]) run_seq(tbl[i], i == 2);

    sw = 8'd255;
    repeat (4) tick();
    press_only();
    sw = 8'd1;
    repeat (4) tick();
    press_measure(1'b0, lat);
    press_measure(1'b0, lat);
    btn = 1'b1;
    repeat (8) tick();
    btn = 1'b0;
    repeat (20) tick();
    chk("calc_busy_valid", valid, 0);
    chk("calc_busy_sym", operand, 132);
    #2 rst = 1'b0;
    #1;
    chk("abort_a", a, 0);
    chk("abort_b", b, 0);
    chk("abort_res", result, 0);
    chk("abort_sign", sign, 0);
    chk("abort_ovf", overflow, 0);
    chk("abort_valid", valid, 0);
    chk("abort_sym", operand, 131);
    #3 rst = 1'b1;
    sw = 8'h5A;
    repeat (5) tick();
    chk("post_rst_track", a, 8'h5A);
    chk("post_rst_valid", valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
